wb_initiator: RTL
=================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of bus cycles waited for wb_ack before an error completion; legal range 1..65535.
REQ-002 i_clk  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  requester has a transaction.
REQ-005 req_ready  output  1  initiator accepts a request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_adr  input  24  word address (WB_ADDR_W).
REQ-008 req_dat  input  16  write data.
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 resp_dat  output  16  read data; 0 for writes and for errors.
REQ-011 resp_err  output  1  completion was a timeout.
REQ-012 wb_cyc, wb_stb  output  1 each  Wishbone cycle and strobe.
REQ-013 wb_we  output  1  Wishbone write enable.
REQ-014 wb_adr  output  24  Wishbone address.
REQ-015 wb_o_dat  output  16  Wishbone write data.
REQ-016 wb_i_dat  input  16  Wishbone read data.
REQ-017 wb_ack  input  1  Wishbone acknowledge; it may be combinational from cyc&stb.

Function
REQ-018 The FSM SHALL have states IDLE, BUS and RESP.
REQ-019 req_ready SHALL equal 1 only in IDLE; a handshake is req_valid&req_ready at a rising edge.
REQ-020 On handshake, the block SHALL register req_we/req_adr/req_dat onto wb_we/wb_adr/wb_o_dat, clear the timeout counter and enter BUS.
REQ-021 In BUS, wb_cyc=wb_stb=1, driven from registered state, and wb_adr/wb_we/wb_o_dat SHALL be held stable.
REQ-022 In BUS, when wb_ack=1 at an edge, the block SHALL enter RESP with resp_err=0 and resp_dat=wb_i_dat for reads, 0 for writes; cyc/stb drop in that same edge.
REQ-023 In BUS without wb_ack, the counter SHALL increment each cycle; when the counter equals TIMEOUT-1 at an edge, the block SHALL enter RESP with resp_err=1, resp_dat=0.
REQ-024 wb_ack and timeout at the same edge: ack SHALL win, giving resp_err=0.
REQ-025 In RESP, resp_valid=1 for exactly one cycle, then IDLE; there is no response back-pressure.
REQ-026 Minimum latency: a handshake at edge N, an ack during cycle N..N+1 and resp_valid during cycle N+1..N+2 give one transaction per 3 cycles.
REQ-027 wb_ack seen in IDLE or RESP SHALL be ignored and SHALL have no side effect.
REQ-028 resp_dat/resp_err SHALL hold their values until the next completion.
REQ-029 The counter width SHALL be 16 bits; it SHALL not wrap, because the timeout terminates the count first.

Reset
REQ-030 While i_rst=1, asynchronously: state=IDLE, wb_cyc=wb_stb=0, wb_we=0, wb_adr=0, wb_o_dat=0, counter=0, resp_valid=0, resp_dat=0, resp_err=0.
REQ-031 Reset mid-BUS SHALL drop cyc/stb immediately and SHALL emit no completion; the first post-reset cycle is IDLE with req_ready=1.

Structure
REQ-032 The state encoding and the WB_ADDR_W/data-width constants SHALL live in the shared config package; TIMEOUT stays a module parameter.
REQ-033 The block SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-034 Write 0x000A to 0x001011, with a responder acking combinationally -> cyc/stb high exactly 1 cycle, wb_o_dat=0x000A, resp_valid 1 cycle, resp_err=0, resp_dat=0.
REQ-035 Read 0x001010 with wb_i_dat=0x0005 and ack delayed 3 cycles -> cyc/stb high 4 cycles, resp_dat=0x0005, resp_err=0.
REQ-036 TIMEOUT=8, no ack -> cyc/stb high exactly 8 cycles, then resp_valid with resp_err=1, resp_dat=0; req_ready returns next cycle.
REQ-037 TIMEOUT=8, ack asserted in the 8th cycle -> resp_err=0 and data captured.
REQ-038 i_rst pulsed on the 2nd BUS cycle -> cyc/stb low asynchronously, no resp_valid, and the next request completes normally.
REQ-039 Back-to-back req_valid held high for 4 requests -> requests are accepted at 3-cycle spacing, in order, and stray wb_ack in IDLE is ignored.

Source files
------------

// File: rtl/wb_initiator_pkg.sv
// Shared configuration for the Wishbone initiator: bus widths and FSM state encoding.
package wb_initiator_pkg;

    localparam int unsigned WB_ADDR_W = 24;
    localparam int unsigned WB_DATA_W = 16;
    localparam int unsigned CNT_W     = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/wb_initiator.sv
// Single-transaction Wishbone initiator: accepts one request, runs one bus cycle
// with an ack timeout, and reports the completion as a one-cycle pulse.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [WB_ADDR_W-1:0] req_adr,
    input  logic [WB_DATA_W-1:0] req_dat,
    output logic                 resp_valid,
    output logic [WB_DATA_W-1:0] resp_dat,
    output logic                 resp_err,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [WB_ADDR_W-1:0] wb_adr,
    output logic [WB_DATA_W-1:0] wb_o_dat,
    input  logic [WB_DATA_W-1:0] wb_i_dat,
    input  logic                 wb_ack
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Handshake, bus and completion flags are pure decodes of the registered state.
    assign req_ready  = (state == ST_IDLE);
    assign wb_cyc     = (state == ST_BUS);
    assign wb_stb     = (state == ST_BUS);
    assign resp_valid = (state == ST_RESP);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_o_dat <= '0;
            resp_dat <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wb_we    <= req_we;
                        wb_adr   <= req_adr;
                        wb_o_dat <= req_dat;
                        cnt      <= '0;
                        state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (wb_ack) begin
                        resp_err <= 1'b0;
                        resp_dat <= wb_we ? '0 : wb_i_dat;
                        state    <= ST_RESP;
                    end else if (cnt == TO_LAST) begin
                        resp_err <= 1'b1;
                        resp_dat <= '0;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
